// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the front-panel button conditioners:
// FSM state encoding, clock-rate-derived timing defaults, and a sizing helper.
package button_conditioner_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        DEB_PRESS   = 3'd1,
        PRESSED     = 3'd2,
        REPEAT      = 3'd3,
        DEB_RELEASE = 3'd4
    } btn_state_t;

    localparam int CLK_HZ = 100_000_000;

    // 5 ms debounce, 0.5 s hold before auto-repeat, 0.1 s repeat period
    localparam int DEF_DB_CYCLES     = CLK_HZ / 200;
    localparam int DEF_HOLD_CYCLES   = CLK_HZ / 2;
    localparam int DEF_REPEAT_CYCLES = CLK_HZ / 10;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; q lags d by two edges.
module sync_2ff (
    input  logic ck,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge ck) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Debounces one raw push button and derives level, press/release pulses and an
// auto-repeating increment pulse stream for the clock/alarm set counters.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic ck,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic level,
    output logic press_pulse,
    output logic release_pulse,
    output logic inc_pulse,
    output logic held
);

    localparam int CNT_W = $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic             btn_s;
    btn_state_t       state;
    logic [CNT_W-1:0] cnt;

    sync_2ff u_sync (
        .ck    (ck),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    // One shared counter serves debounce, hold and repeat timing; it is
    // zeroed on every state change so each phase times from its own entry.
    always_ff @(posedge ck) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            inc_pulse     <= 1'b0;
            held          <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            inc_pulse     <= 1'b0;

            case (state)
                IDLE: begin
                    if (btn_s) begin
                        state <= DEB_PRESS;
                        cnt   <= '0;
                    end
                end

                DEB_PRESS: begin
                    if (!btn_s) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state       <= PRESSED;
                        cnt         <= '0;
                        level       <= 1'b1;
                        press_pulse <= 1'b1;
                        inc_pulse   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                PRESSED: begin
                    if (!btn_s) begin
                        state <= DEB_RELEASE;
                        cnt   <= '0;
                    end else if (repeat_en && cnt == HOLD_LAST) begin
                        state     <= REPEAT;
                        cnt       <= '0;
                        held      <= 1'b1;
                        inc_pulse <= 1'b1;
                    end else if (repeat_en) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end

                REPEAT: begin
                    if (!btn_s) begin
                        state <= DEB_RELEASE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end else if (!repeat_en) begin
                        state <= PRESSED;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end else if (cnt == REP_LAST) begin
                        cnt       <= '0;
                        inc_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DEB_RELEASE: begin
                    // A bounce back to 1 is not a new press; only the hold timer restarts.
                    if (btn_s) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state         <= IDLE;
                        cnt           <= '0;
                        level         <= 1'b0;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized bench for button_conditioner against a level/run-length reference model.
module tb_button_conditioner;

    localparam int DB   = 4;
    localparam int HOLD = 20;
    localparam int REP  = 8;

    logic ck = 1'b0;
    logic reset;
    logic btn_in;
    logic repeat_en;
    logic level;
    logic press_pulse;
    logic release_pulse;
    logic inc_pulse;
    logic held;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: two-sample input delay, accepted level, length of the
    // current run of samples that disagree with the level, and a hold/repeat timer.
    bit m_q1, m_s;
    bit m_lvl, m_held, m_press, m_release, m_inc;
    int m_run, m_tmr;

    button_conditioner #(
        .DB_CYCLES     (DB),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP)
    ) dut (
        .ck            (ck),
        .reset         (reset),
        .btn_in        (btn_in),
        .repeat_en     (repeat_en),
        .level         (level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .inc_pulse     (inc_pulse),
        .held          (held)
    );

    always #5 ck = ~ck;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_edge();
        bit s;
        m_press   = 1'b0;
        m_release = 1'b0;
        m_inc     = 1'b0;
        if (reset) begin
            m_q1 = 0; m_s = 0; m_lvl = 0; m_held = 0; m_run = 0; m_tmr = 0;
            return;
        end
        s    = m_s;
        m_s  = m_q1;
        m_q1 = btn_in;
        if (!m_lvl) begin
            // The first 1 sample starts the debounce, then DB more are required.
            if (s) begin
                m_run++;
                if (m_run == DB + 1) begin
                    m_lvl = 1; m_press = 1; m_inc = 1; m_run = 0; m_tmr = 0; m_held = 0;
                end
            end else begin
                m_run = 0;
            end
        end else if (!s) begin
            m_held = 0;
            m_run++;
            if (m_run == DB + 1) begin
                m_lvl = 0; m_release = 1; m_run = 0;
            end
        end else if (m_run > 0) begin
            m_run = 0;
            m_tmr = 0;
        end else if (!m_held) begin
            if (repeat_en) begin
                if (m_tmr == HOLD - 1) begin
                    m_held = 1; m_inc = 1; m_tmr = 0;
                end else begin
                    m_tmr++;
                end
            end else begin
                m_tmr = 0;
            end
        end else begin
            if (!repeat_en) begin
                m_held = 0; m_tmr = 0;
            end else if (m_tmr == REP - 1) begin
                m_inc = 1; m_tmr = 0;
            end else begin
                m_tmr++;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge ck);
        model_edge();
        #1;
        check(tag, {27'd0, level, press_pulse, release_pulse, inc_pulse, held},
                   {27'd0, m_lvl, m_press, m_release, m_inc, m_held});
    endtask

    task automatic run_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;
        run_cycles(3, "reset");
        check("reset_outs", {27'd0, level, press_pulse, release_pulse, inc_pulse, held}, 32'd0);
        reset = 1'b0;
        run_cycles(4, "idle");

        // Steady press: press_pulse lands on the 7th edge that samples btn_in=1.
        btn_in = 1'b1;
        n = 0;
        do begin
            step("press");
            n++;
        end while (!press_pulse && n < 20);
        check("press_latency", n, DB + 3);
        check("press_inc", inc_pulse, 1'b1);
        run_cycles(60, "hold_norepeat");
        btn_in = 1'b0;
        n = 0;
        do begin
            step("release");
            n++;
        end while (!release_pulse && n < 20);
        check("release_latency", n, DB + 3);
        run_cycles(5, "idle");

        // Random segments: short glitches, long holds, bounces, repeat_en flips, resets.
        for (int seg = 0; seg < 220; seg++) begin
            int kind;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                reset = 1'b1;
                run_cycles($urandom_range(1, 2), "rand_reset");
                reset = 1'b0;
            end else if (kind <= 2) begin
                repeat_en = ($urandom_range(0, 3) != 0);
                run_cycles(1, "rand_en");
            end else if (kind <= 5) begin
                btn_in = ~btn_in;
                run_cycles($urandom_range(1, DB + 3), "rand_short");
            end else begin
                btn_in = ~btn_in;
                for (int c = $urandom_range(DB + 4, 70); c > 0; c--) begin
                    if ($urandom_range(0, 24) == 0) repeat_en = ~repeat_en;
                    step("rand_long");
                end
            end
        end

        btn_in = 1'b0;
        run_cycles(DB + 6, "settle");
        check("final_level", level, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
